lsu: RTL and testbench

Load/store unit for the RISC-V core: the initiator side of the byte-addressable data memory port. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the memory's read address and sized write port. It absorbs the memory's one-cycle registered read latency, sign- or zero-extends load data, and returns a result or fault over a valid/ready response channel.

---
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-outstanding requester for a byte-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module lsu #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  mem_wr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | read address or sized write presented to memory
  // WAIT  | memory read data valid, captured into resp_rdata
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  op_q;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        illegal;
  logic        out_of_range;
  logic        misaligned;
  logic        fault;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE);

  always_comb begin
    case (req_op[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    if (req_store) illegal = (req_op > 3'd2);
    else           illegal = (req_op == 3'b011) || (req_op[2:1] == 2'b11);
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    end_addr     = {1'b0, req_addr} + {30'd0, size};
    out_of_range = (end_addr > 33'(MEM_SIZE));
    misaligned   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned   = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    fault = illegal || out_of_range || misaligned;
  end

  always_comb begin
    load_ext = mem_rd_data;
    case (op_q)
      3'b000:  load_ext = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
      3'b001:  load_ext = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
      3'b100:  load_ext = {24'd0, mem_rd_data[7:0]};
      3'b101:  load_ext = {16'd0, mem_rd_data[15:0]};
      default: load_ext = mem_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      op_q        <= 3'd0;
      resp_valid  <= 1'b0;
      resp_fault  <= 1'b0;
      resp_rdata  <= 32'd0;
      mem_wr      <= 2'd0;
      mem_rd_addr <= 32'd0;
      mem_wr_addr <= 32'd0;
      mem_wr_data <= 32'd0;
    end else begin
      mem_wr <= 2'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            op_q       <= req_op;
            resp_rdata <= 32'd0;
            resp_fault <= fault;
            if (fault) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ISSUE;
              // memory-side registers load here so they are valid throughout ISSUE
              if (req_store) begin
                mem_wr      <= req_op[1:0] + 2'd1;
                mem_wr_addr <= req_addr;
                mem_wr_data <= req_wdata;
              end else begin
                mem_rd_addr <= req_addr;
              end
            end
          end
        end
        ISSUE: begin
          if (store_q) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          resp_rdata <= load_ext;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: behavioural byte-array memory plus a request-level reference model.
module tb_lsu;
  localparam int unsigned MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic [1:0]  mem_wr;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [MEM_SIZE] = '{default: 8'h00};
  logic [7:0] ref_mem [MEM_SIZE] = '{default: 8'h00};

  lsu #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) % MEM_SIZE);
  endfunction

  // Memory environment: registered read, byte-addressed sized write
  always @(posedge clk) begin
    mem_rd_data <= {mem[wrap(mem_rd_addr, 3)], mem[wrap(mem_rd_addr, 2)],
                    mem[wrap(mem_rd_addr, 1)], mem[wrap(mem_rd_addr, 0)]};
    if (mem_wr >= 2'd1) mem[wrap(mem_wr_addr, 0)] <= mem_wr_data[7:0];
    if (mem_wr >= 2'd2) mem[wrap(mem_wr_addr, 1)] <= mem_wr_data[15:8];
    if (mem_wr == 2'd3) begin
      mem[wrap(mem_wr_addr, 2)] <= mem_wr_data[23:16];
      mem[wrap(mem_wr_addr, 3)] <= mem_wr_data[31:24];
    end
  end

  function automatic int op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_fault(input bit st, input logic [2:0] op, input logic [31:0] a);
    longint unsigned ea = a;
    int sz = op_size(op);
    bit ill = st ? (op > 3'd2) : (op == 3'd3 || op >= 3'd6);
    bit oor = (ea + longint'(sz)) > longint'(MEM_SIZE);
    bit mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (ea % longint'(sz)) != 0;
`endif
    return ill || oor || mis;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int sz = op_size(op);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    if (!op[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input int sz);
    for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction, entered and left on a negedge with the LSU idle
  task automatic do_req(input string tag, input bit st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    bit          f;
    logic [31:0] er, rd_addr, wr_addr, wr_data, mask;
    logic [1:0]  wr_val;
    int          sz, el, lat, wr_cnt;
    sz   = op_size(op);
    f    = model_fault(st, op, a);
    er   = (!st && !f) ? model_load(op, a) : 32'd0;
    el   = f ? 1 : (st ? 2 : 3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    if (st && !f) model_store(a, wd, sz);
    wr_cnt = 0; wr_val = 2'd0; wr_addr = 32'd0; wr_data = 32'd0;

    req_valid = 1'b1; req_store = st; req_op = op; req_addr = a; req_wdata = wd;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom);
    lat = 1;
    rd_addr = mem_rd_addr;
    while (lat < 20) begin
      if (mem_wr != 2'd0) begin
        wr_cnt++; wr_val = mem_wr; wr_addr = mem_wr_addr; wr_data = mem_wr_data;
      end
      if (resp_valid) break;
      @(negedge clk); lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " fault"}, 32'(resp_fault), 32'(f));
    check({tag, " rdata"}, resp_rdata, er);
    if (!st && !f) check({tag, " rd_addr"}, rd_addr, a);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mem_wr != 2'd0) wr_cnt++;
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold rdata"}, resp_rdata, er);
      check({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (mem_wr != 2'd0) wr_cnt++;
    check({tag, " valid drop"}, 32'(resp_valid), 32'd0);
    check({tag, " ready back"}, 32'(req_ready), 32'd1);
    check({tag, " wr pulses"}, 32'(wr_cnt), (st && !f) ? 32'd1 : 32'd0);
    if (st && !f) begin
      check({tag, " wr size"}, 32'(wr_val), 32'(op[1:0] + 2'd1));
      check({tag, " wr addr"}, wr_addr, a);
      check({tag, " wr data"}, wr_data & mask, wd & mask);
    end
  endtask

  initial begin
    int bad;
    logic [2:0]  op;
    logic [31:0] a;
    bit          st;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_fault", 32'(resp_fault), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst mem_rd_addr", mem_rd_addr, 32'd0);
    check("rst mem_wr_addr", mem_wr_addr, 32'd0);
    check("rst mem_wr_data", mem_wr_data, 32'd0);

    do_req("SW 10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    do_req("LW 10", 0, 3'b010, 32'h10, 32'h0, 0);
    do_req("LB 13", 0, 3'b000, 32'h13, 32'h0, 1);
    do_req("LBU 13", 0, 3'b100, 32'h13, 32'h0, 0);
    do_req("LH 12", 0, 3'b001, 32'h12, 32'h0, 0);
    do_req("LHU 12", 0, 3'b101, 32'h12, 32'h0, 2);
    do_req("LB 10", 0, 3'b000, 32'h10, 32'h0, 0);
    do_req("SW 20", 1, 3'b010, 32'h20, 32'h0, 0);
    do_req("SB 21", 1, 3'b000, 32'h21, 32'h12345678, 0);
    do_req("LW 20", 0, 3'b010, 32'h20, 32'h0, 0);
    do_req("LW 3FE", 0, 3'b010, 32'h3FE, 32'h0, 0);
    do_req("LW 3FC", 0, 3'b010, 32'h3FC, 32'h0, 0);
    do_req("LB 3FF", 0, 3'b000, 32'h3FF, 32'h0, 0);
    do_req("LH 3FF", 0, 3'b001, 32'h3FF, 32'h0, 0);
    do_req("LB FFFFFFFF", 0, 3'b000, 32'hFFFF_FFFF, 32'h0, 0);
    do_req("SW FFFFFFFE", 1, 3'b010, 32'hFFFF_FFFE, 32'h1, 0);
    do_req("LD op3", 0, 3'b011, 32'h10, 32'h0, 0);
    do_req("ST op4", 1, 3'b100, 32'h10, 32'hFFFFFFFF, 0);
    do_req("LW hold5", 0, 3'b010, 32'h10, 32'h0, 5);
    do_req("SW 14", 1, 3'b010, 32'h14, 32'h00000011, 0);
    do_req("LW 11", 0, 3'b010, 32'h11, 32'h0, 0);
    do_req("SH 31", 1, 3'b001, 32'h31, 32'h0000ABCD, 0);

    // reset during WAIT drops the load response
    req_valid = 1'b1; req_store = 1'b0; req_op = 3'b010; req_addr = 32'h10;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("rstwait pre valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstwait in-reset valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("rstwait ready", 32'(req_ready), 32'd1);
    bad = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) bad++; end
    check("rstwait no resp", 32'(bad), 32'd0);

    // reset coinciding with store ISSUE still commits
    req_valid = 1'b1; req_store = 1'b1; req_op = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(negedge clk); req_valid = 1'b0;
    check("rstissue mem_wr", 32'(mem_wr), 32'd3);
    model_store(32'h30, 32'hCAFEF00D, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstissue wr cleared", 32'(mem_wr), 32'd0);
    @(negedge clk);
    do_req("LW 30", 0, 3'b010, 32'h30, 32'h0, 0);

    // reset at the would-be accept edge never writes
    req_valid = 1'b1; req_store = 1'b1; req_op = 3'b010; req_addr = 32'h34; req_wdata = 32'h55555555;
    rst_n = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    bad = 0;
    repeat (3) begin if (mem_wr != 2'd0 || resp_valid) bad++; @(negedge clk); end
    check("rstaccept no activity", 32'(bad), 32'd0);
    do_req("LW 34", 0, 3'b010, 32'h34, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 3) == 0) op = 3'($urandom);
      else if (st) op = 3'($urandom_range(0, 2));
      else case ($urandom_range(0, 4))
        0: op = 3'b000; 1: op = 3'b001; 2: op = 3'b010; 3: op = 3'b100; default: op = 3'b101;
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'($urandom_range(1016, 1031));
        default: a = $urandom;
      endcase
      do_req("rand", st, op, a, $urandom, $urandom_range(0, 2));
    end

    bad = 0;
    for (int i = 0; i < int'(MEM_SIZE); i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final memory image", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
